// File: rtl/alu_pipelined_pkg.sv
// Shared constants and types for the pipelined ALU and the request scheduler in front of it.
// Holds datapath width, ALU latency, opcode encoding and the flag layout.
package alu_pipelined_pkg;
  localparam int WIDTH        = 32;
  localparam int NREQ_DEFAULT = 4;
  localparam int ALU_LAT      = 2;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic of;
  } alu_flags_t;
endpackage

// File: rtl/alu_pipelined.sv
// Two-stage ALU: operands are registered, then the result and flags are registered.
// Latency ALU_LAT (2) cycles; no backpressure, accepts one op per cycle.
module alu_pipelined
  import alu_pipelined_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       alu_ctrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_res_q, s2_res_d;
  alu_flags_t       s2_flg_q, s2_flg_d;

  logic [WIDTH-1:0] b_eff, res;
  logic [WIDTH:0]   sum;
  logic             cin, carry, ovf, add_ovf;

  always_comb begin
    s1_vld_d = valid_i;
    s1_a_d   = a_i;
    s1_b_d   = b_i;
    s1_op_d  = alu_ctrl_i;
  end

  // Subtract and compare share the adder as a + ~b + 1; C is the no-borrow carry.
  always_comb begin
    b_eff = s1_b_q;
    cin   = 1'b0;
    if (s1_op_q == ALU_SUB || s1_op_q == ALU_SLT) begin
      b_eff = ~s1_b_q;
      cin   = 1'b1;
    end
    sum     = {1'b0, s1_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    add_ovf = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (s1_op_q)
      ALU_ADD, ALU_SUB: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = add_ovf;
      end
      ALU_AND: res = s1_a_q & s1_b_q;
      ALU_OR:  res = s1_a_q | s1_b_q;
      ALU_XOR: res = s1_a_q ^ s1_b_q;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: res = '0;
    endcase
    s2_vld_d    = s1_vld_q;
    s2_res_d    = res;
    s2_flg_d.z  = (res == '0);
    s2_flg_d.n  = res[WIDTH-1];
    s2_flg_d.c  = carry;
    s2_flg_d.of = ovf;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_op_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_res_q <= '0;
      s2_flg_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_op_q  <= s1_op_d;
      s2_vld_q <= s2_vld_d;
      s2_res_q <= s2_res_d;
      s2_flg_q <= s2_flg_d;
    end
  end

  assign valid_o  = s2_vld_q;
  assign result_o = s2_res_q;
  assign flags_o  = s2_flg_q;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the pointer upward, with wrap.
// Zero latency; pointer advances past the winner only when accept_i confirms the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic [PW:0]   idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req_i[idx[PW-1:0]]) begin
        found                = 1'b1;
        gnt_o[idx[PW-1:0]]   = 1'b1;
        gidx                 = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i && found) ptr_d = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one pipelined ALU among NREQ requesters; results return via per-requester response slots.
// Request to rsp_valid is 3 cycles; a held response blocks only its own requester (one op in flight each).
module alu_rr_scheduler
  import alu_pipelined_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic [NREQ*4-1:0]     req_ctrl_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [NREQ*WIDTH-1:0] rsp_result_o,
  output logic [NREQ*4-1:0]     rsp_flags_o,
  output logic [NREQ-1:0]       busy_o
);
  localparam int TAGW = $clog2(NREQ);

  logic [NREQ-1:0]  elig, arb_gnt, grant, slot_wr, slot_hs;
  logic             issue_vld;
  logic [TAGW-1:0]  gnt_idx;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [3:0]       alu_ctrl, alu_flags;
  logic             alu_vld;

  logic [NREQ-1:0]  busy_q, busy_d;
  logic             tag_vld_q [ALU_LAT];
  logic             tag_vld_d [ALU_LAT];
  logic [TAGW-1:0]  tag_idx_q [ALU_LAT];
  logic [TAGW-1:0]  tag_idx_d [ALU_LAT];
  logic             tag_out_vld;
  logic [TAGW-1:0]  tag_out_idx;

  logic [NREQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [WIDTH-1:0] rsp_res_q [NREQ];
  logic [WIDTH-1:0] rsp_res_d [NREQ];
  alu_flags_t       rsp_flg_q [NREQ];
  alu_flags_t       rsp_flg_d [NREQ];

  assign elig = req_valid_i & ~busy_q;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (elig),
    .accept_i (issue_vld),
    .gnt_o    (arb_gnt)
  );

  // No grant may escape while reset is asserted, even with valids high.
  assign grant       = arb_gnt & {NREQ{rst_ni}};
  assign issue_vld   = |grant;
  assign req_ready_o = grant;

  always_comb begin
    gnt_idx  = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        gnt_idx  = TAGW'(k);
        alu_a    = req_a_i[k*WIDTH +: WIDTH];
        alu_b    = req_b_i[k*WIDTH +: WIDTH];
        alu_ctrl = req_ctrl_i[k*4 +: 4];
      end
    end
  end

  alu_pipelined u_alu (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (issue_vld),
    .a_i        (alu_a),
    .b_i        (alu_b),
    .alu_ctrl_i (alu_ctrl),
    .valid_o    (alu_vld),
    .result_o   (alu_res),
    .flags_o    (alu_flags)
  );

  always_comb begin
    tag_vld_d[0] = issue_vld;
    tag_idx_d[0] = gnt_idx;
    for (int s = 1; s < ALU_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  assign tag_out_vld = tag_vld_q[ALU_LAT-1];
  assign tag_out_idx = tag_idx_q[ALU_LAT-1];

  always_comb begin
    slot_wr = '0;
    slot_hs = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot_wr[k] = alu_vld && tag_out_vld && (tag_out_idx == TAGW'(k));
      slot_hs[k] = rsp_vld_q[k] && rsp_ready_i[k];
    end
  end

  always_comb begin
    rsp_vld_d = rsp_vld_q;
    busy_d    = busy_q;
    for (int k = 0; k < NREQ; k++) begin
      rsp_res_d[k] = rsp_res_q[k];
      rsp_flg_d[k] = rsp_flg_q[k];
      if (slot_hs[k]) begin
        rsp_vld_d[k] = 1'b0;
        rsp_res_d[k] = '0;
        rsp_flg_d[k] = '0;
      end
      if (slot_wr[k]) begin
        rsp_vld_d[k] = 1'b1;
        rsp_res_d[k] = alu_res;
        rsp_flg_d[k] = alu_flags_t'(alu_flags);
      end
      if (grant[k])        busy_d[k] = 1'b1;
      else if (slot_hs[k]) busy_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q    <= '0;
      rsp_vld_q <= '0;
      for (int s = 0; s < ALU_LAT; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_idx_q[s] <= '0;
      end
      for (int k = 0; k < NREQ; k++) begin
        rsp_res_q[k] <= '0;
        rsp_flg_q[k] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      rsp_vld_q <= rsp_vld_d;
      for (int s = 0; s < ALU_LAT; s++) begin
        tag_vld_q[s] <= tag_vld_d[s];
        tag_idx_q[s] <= tag_idx_d[s];
      end
      for (int k = 0; k < NREQ; k++) begin
        rsp_res_q[k] <= rsp_res_d[k];
        rsp_flg_q[k] <= rsp_flg_d[k];
      end
    end
  end

  always_comb begin
    rsp_result_o = '0;
    rsp_flags_o  = '0;
    for (int k = 0; k < NREQ; k++) begin
      rsp_result_o[k*WIDTH +: WIDTH] = rsp_res_q[k];
      rsp_flags_o[k*4 +: 4]          = rsp_flg_q[k];
    end
  end

  assign rsp_valid_o = rsp_vld_q;
  assign busy_o      = busy_q;

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(grant));
  a_tag_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tag_out_vld |-> busy_q[tag_out_idx]);
  a_tag_lockstep: assert property (@(posedge clk_i) disable iff (!rst_ni) alu_vld == tag_out_vld);

  for (genvar k = 0; k < NREQ; k++) begin : g_slot_chk
    a_no_overwrite: assert property (@(posedge clk_i) disable iff (!rst_ni)
      slot_wr[k] |-> !rsp_vld_q[k]);
    a_rsp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (rsp_vld_q[k] && !rsp_ready_i[k]) |=>
        (rsp_vld_q[k] && $stable(rsp_res_q[k]) && $stable(rsp_flg_q[k])));
  end
endmodule
